ysyx_24110015_idu: RTL
======================

YSYX_24110015_IDU -- requirements
Module: ysyx_24110015_idu

Interface -- parameters (name, default, meaning)
REQ-001 SHALL provide RVE, default 1; when 1, any register index above 15 is illegal.
REQ-002 SHALL provide RESET_PC, default 32'h8000_0000; reset value of out_pc.

Interface -- ports (name  direction  width  meaning)
REQ-003 SHALL provide clk  input  1  sole clock, rising edge.
REQ-004 SHALL provide rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL provide in_valid  input  1, in_ready  output  1, in_pc  input  32, in_inst  input  32: fetch-side handshake and payload.
REQ-006 SHALL provide flush  input  1: kill from the redirect unit.
REQ-007 SHALL provide out_valid  output  1, out_ready  input  1: execute-side handshake.
REQ-008 SHALL provide out_pc  32, out_rs1/out_rs2/out_rd  5, out_imm  32, out_alu_op  4, out_reg_wen, out_mem_ren, out_mem_wen  1, out_mem_len  2 (0=B,1=H,2=W), out_mem_sext  1, out_branch  1, out_br_funct3  3, out_jal, out_jalr, out_ebreak, out_illegal  1; all outputs.

Function
REQ-009 SHALL hold one registered slot with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-010 SHALL drive in_ready = !out_valid || out_ready (combinational, no dependence on in_valid).
REQ-011 SHALL accept when in_valid && in_ready; the decoded result appears on outputs the next cycle (latency 1); state becomes FULL.
REQ-012 SHALL leave FULL -> EMPTY when out_ready && !in_valid; FULL with simultaneous accept and drain SHALL stay FULL holding the new result (full throughput, 1 instr/cycle).
REQ-013 SHALL hold all out_* payload stable while out_valid && !out_ready.
REQ-014 SHALL, on flush, go EMPTY next cycle and discard any same-cycle input; flush has priority over accept.
REQ-015 SHALL decode RV32I/E base: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, SYSTEM(ebreak only), MISC-MEM (fence as NOP, reg_wen=0).
REQ-016 SHALL produce I/S/B/U/J immediates sign-extended to 32 bits; shift-immediates SHALL carry shamt in imm[4:0], zeros above.
REQ-017 SHALL force out_reg_wen=0 when rd==0.
REQ-018 SHALL set out_illegal for unknown opcode, bad funct3/funct7, inst[1:0]!=2'b11, or (RVE && any used index >15); illegal results still flow through the handshake with all side-effect flags (reg_wen, mem_*, branch, jal, jalr) cleared.
REQ-019 SHALL set out_ebreak only for exactly 32'h0010_0073; any other SYSTEM encoding is illegal.

Reset
REQ-020 SHALL, while rst=1, asynchronously force out_valid=0 and out_pc=RESET_PC with every other output 0; in_ready SHALL read 1 once out_valid=0.
REQ-021 SHALL discard any in-flight result on reset mid-operation; first accept possible on the first rising edge after rst deasserts.

Structure
REQ-022 SHALL take opcode constants, the alu_op encoding (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, COPY_B) and mem_len codes from shared package ysyx_24110015_pkg.
REQ-023 SHALL place immediate generation in combinational sub-module ysyx_24110015_imm_gen (inst, format -> imm).

Verification
REQ-024 addi x1,x0,5 (32'h0050_0093), out_ready=1 -> next cycle out_valid=1, rd=1, rs1=0, imm=5, alu_op=ADD, reg_wen=1.
REQ-025 lw x2,-4(x1) (32'hFFC0_A103) -> imm=32'hFFFF_FFFC, mem_ren=1, mem_len=2, mem_sext=1, rd=2, rs1=1.
REQ-026 Back-to-back in_valid with out_ready low for 3 cycles -> in_ready=0 from 2nd cycle, payload stable, no instruction lost or duplicated after release.
REQ-027 flush asserted together with in_valid while FULL -> out_valid=0 next cycle; input dropped.
REQ-028 32'h0000_0000 -> out_illegal=1, reg_wen=0; 32'h0010_0073 -> out_ebreak=1, illegal=0; add x16,x1,x2 (RVE=1) -> illegal=1.
REQ-029 rst pulse while FULL and stalled -> out_valid=0 immediately, out_pc=32'h8000_0000.

Source files
------------

// File: rtl/ysyx_24110015_pkg.sv
// Shared decode constants and types for the ysyx_24110015 decode stage.
// Opcodes, ALU operation codes, memory access sizes and the decoded payload bundle.
package ysyx_24110015_pkg;

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_COPY_B
    } alu_op_e;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2
    } mem_len_e;

    typedef enum logic [2:0] {
        FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SH
    } imm_fmt_e;

    typedef enum logic {
        SLOT_EMPTY,
        SLOT_FULL
    } slot_e;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        alu_op_e     alu_op;
        logic        reg_wen;
        logic        mem_ren;
        logic        mem_wen;
        mem_len_e    mem_len;
        logic        mem_sext;
        logic        branch;
        logic [2:0]  br_funct3;
        logic        jal;
        logic        jalr;
        logic        ebreak;
        logic        illegal;
    } dec_t;

    // alt selects SUB/SRA; callers pass 0 where the alternate form does not exist
    function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        op = ALU_ADD;
        case (f3)
            3'd0:    op = alt ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = alt ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ysyx_24110015_imm_gen.sv
// Immediate generator: sign-extended I/S/B/U/J immediates and zero-extended shift amounts.
module ysyx_24110015_imm_gen
    import ysyx_24110015_pkg::*;
(
    input  logic [31:0] inst,
    input  imm_fmt_e    fmt,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I:   imm = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm = {inst[31:12], 12'b0};
            FMT_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            FMT_SH:  imm = {27'b0, inst[24:20]};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_24110015_idu.sv
// RV32I/E decode stage with a single registered output slot and valid/ready handshakes.
// state | meaning: SLOT_EMPTY | no result held; SLOT_FULL | decoded result presented on out_*
module ysyx_24110015_idu
    import ysyx_24110015_pkg::*;
#(
    parameter bit          RVE      = 1'b1,
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic [31:0] out_imm,
    output logic [3:0]  out_alu_op,
    output logic        out_reg_wen,
    output logic        out_mem_ren,
    output logic        out_mem_wen,
    output logic [1:0]  out_mem_len,
    output logic        out_mem_sext,
    output logic        out_branch,
    output logic [2:0]  out_br_funct3,
    output logic        out_jal,
    output logic        out_jalr,
    output logic        out_ebreak,
    output logic        out_illegal
);

    slot_e       state_q, state_d;
    logic        load;
    dec_t        dec_d, dec_q;
    logic [31:0] pc_q;
    imm_fmt_e    fmt;
    logic [31:0] imm;
    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic        use_rs1, use_rs2, use_rd, wen, bad, rve_bad;

    assign opcode = in_inst[6:0];
    assign f3     = in_inst[14:12];
    assign f7     = in_inst[31:25];

    ysyx_24110015_imm_gen u_imm_gen (
        .inst (in_inst),
        .fmt  (fmt),
        .imm  (imm)
    );

    always_comb begin
        dec_d   = '0;
        fmt     = FMT_NONE;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        wen     = 1'b0;
        bad     = 1'b0;
        case (opcode)
            OPC_LUI: begin
                use_rd = 1'b1; wen = 1'b1; fmt = FMT_U; dec_d.alu_op = ALU_COPY_B;
            end
            OPC_AUIPC: begin
                use_rd = 1'b1; wen = 1'b1; fmt = FMT_U;
            end
            OPC_JAL: begin
                use_rd = 1'b1; wen = 1'b1; fmt = FMT_J; dec_d.jal = 1'b1;
            end
            OPC_JALR: begin
                use_rd = 1'b1; use_rs1 = 1'b1; wen = 1'b1; fmt = FMT_I; dec_d.jalr = 1'b1;
                bad = (f3 != 3'd0);
            end
            OPC_BRANCH: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; fmt = FMT_B;
                dec_d.branch = 1'b1; dec_d.br_funct3 = f3; dec_d.alu_op = ALU_SUB;
                bad = (f3 == 3'd2) || (f3 == 3'd3);
            end
            OPC_LOAD: begin
                use_rd = 1'b1; use_rs1 = 1'b1; wen = 1'b1; fmt = FMT_I;
                dec_d.mem_ren  = 1'b1;
                dec_d.mem_len  = mem_len_e'(f3[1:0]);
                dec_d.mem_sext = !f3[2];
                bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
            end
            OPC_STORE: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; fmt = FMT_S;
                dec_d.mem_wen = 1'b1;
                dec_d.mem_len = mem_len_e'(f3[1:0]);
                bad = (f3 > 3'd2);
            end
            OPC_OPIMM: begin
                use_rd = 1'b1; use_rs1 = 1'b1; wen = 1'b1;
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    fmt = FMT_SH;
                    dec_d.alu_op = alu_from_funct3(f3, in_inst[30]);
                    bad = (f3 == 3'd1) ? (f7 != 7'h00) : (f7 != 7'h00 && f7 != 7'h20);
                end else begin
                    fmt = FMT_I;
                    dec_d.alu_op = alu_from_funct3(f3, 1'b0);
                end
            end
            OPC_OP: begin
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; wen = 1'b1;
                dec_d.alu_op = alu_from_funct3(f3, in_inst[30]);
                bad = !((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            end
            // fence executes as a NOP; only the base funct3 is recognised
            OPC_MISCMEM: bad = (f3 != 3'd0);
            OPC_SYSTEM: begin
                if (in_inst == INST_EBREAK) dec_d.ebreak = 1'b1;
                else                        bad = 1'b1;
            end
            default: bad = 1'b1;
        endcase

        rve_bad = RVE && ((use_rs1 && in_inst[19]) || (use_rs2 && in_inst[24]) ||
                          (use_rd && in_inst[11]));
        dec_d.illegal = bad || rve_bad || (in_inst[1:0] != 2'b11);
        dec_d.rs1     = use_rs1 ? in_inst[19:15] : 5'd0;
        dec_d.rs2     = use_rs2 ? in_inst[24:20] : 5'd0;
        dec_d.rd      = use_rd  ? in_inst[11:7]  : 5'd0;
        dec_d.imm     = imm;
        dec_d.reg_wen = wen && (dec_d.rd != 5'd0);

        if (dec_d.illegal) begin
            dec_d.reg_wen   = 1'b0;
            dec_d.mem_ren   = 1'b0;
            dec_d.mem_wen   = 1'b0;
            dec_d.mem_len   = MEM_B;
            dec_d.mem_sext  = 1'b0;
            dec_d.branch    = 1'b0;
            dec_d.br_funct3 = 3'd0;
            dec_d.jal       = 1'b0;
            dec_d.jalr      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= SLOT_EMPTY;
        else     state_q <= state_d;
    end

    // flush wins over a same-cycle accept; a drain with a new accept stays full
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        in_ready = (state_q == SLOT_EMPTY) || out_ready;
        if (flush) begin
            state_d = SLOT_EMPTY;
        end else if (in_valid && in_ready) begin
            state_d = SLOT_FULL;
            load    = 1'b1;
        end else if (out_ready) begin
            state_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            dec_q <= '0;
        end else if (load) begin
            pc_q  <= in_pc;
            dec_q <= dec_d;
        end
    end

    assign out_valid     = (state_q == SLOT_FULL);
    assign out_pc        = pc_q;
    assign out_rs1       = dec_q.rs1;
    assign out_rs2       = dec_q.rs2;
    assign out_rd        = dec_q.rd;
    assign out_imm       = dec_q.imm;
    assign out_alu_op    = dec_q.alu_op;
    assign out_reg_wen   = dec_q.reg_wen;
    assign out_mem_ren   = dec_q.mem_ren;
    assign out_mem_wen   = dec_q.mem_wen;
    assign out_mem_len   = dec_q.mem_len;
    assign out_mem_sext  = dec_q.mem_sext;
    assign out_branch    = dec_q.branch;
    assign out_br_funct3 = dec_q.br_funct3;
    assign out_jal       = dec_q.jal;
    assign out_jalr      = dec_q.jalr;
    assign out_ebreak    = dec_q.ebreak;
    assign out_illegal   = dec_q.illegal;

endmodule
